// File: rtl/side_buf_if.sv
// Side-buffer bundle: deflected-flit push, router free-slot mask, re-injection result.
interface side_buf_if #(
    parameter int unsigned FLIT_W = 32
);
    logic              push_vld;
    logic [FLIT_W-1:0] push_flit;
    logic [3:0]        free_vec;
    logic              full;
    logic              redirect_gnt;
    logic [1:0]        rand_num;
    logic              reinj_vld;
    logic [3:0]        reinj_chnl;
    logic [FLIT_W-1:0] reinj_flit;
    logic              ovf_err;

    modport master (
        output push_vld, push_flit, free_vec,
        input  full, redirect_gnt, rand_num, reinj_vld, reinj_chnl, reinj_flit, ovf_err
    );

    modport slave (
        input  push_vld, push_flit, free_vec,
        output full, redirect_gnt, rand_num, reinj_vld, reinj_chnl, reinj_flit, ovf_err
    );
endinterface

// File: rtl/side_buf_ctrl.sv
// Deflection side buffer: circular FIFO with round-robin re-injection into free router slots.
// Define SIDE_BUF_STARVE_EN to add the starvation counter and forced random redirect.
module side_buf_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STARVE_TH = 8,
    parameter int unsigned FLIT_W    = 32
) (
    input  logic     clk,
    input  logic     reset,
    side_buf_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [FLIT_W-1:0] flit_int_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_TH < 1 || STARVE_TH > 255) begin : g_param_check
        $error("side_buf_ctrl: DEPTH must be a power of two >= 2 and STARVE_TH in 1..255");
    end

    flit_int_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [1:0]    rr;
    logic [7:0]    lfsr;
    logic          ovf;

    logic          full;
    logic          empty;
    logic          any_free;
    logic          push_ok;
    logic          pop;
    logic          redirect;
    logic          found;
    logic [1:0]    cand;
    logic [1:0]    pick_idx;

    assign full     = (count == (PW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign any_free = |bus.free_vec;
    assign push_ok  = bus.push_vld & ~full;
    assign pop      = ~empty & (any_free | redirect);

`ifdef SIDE_BUF_STARVE_EN
    logic [7:0] starve_cnt;

    assign redirect = ~empty & ~any_free & (starve_cnt == 8'(STARVE_TH));

    // Redirect always pops, so the counter never runs past STARVE_TH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (!any_free) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign redirect = 1'b0;
`endif

    // First free slot at or above rr, wrapping 3 -> 0.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = rr + 2'(i);
            if (!found && bus.free_vec[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        bus.reinj_vld  = pop;
        bus.reinj_chnl = '0;
        bus.reinj_flit = '0;
        if (pop) begin
            bus.reinj_flit = mem[rd_ptr];
            bus.reinj_chnl = redirect ? (4'b0001 << bus.rand_num) : (4'b0001 << pick_idx);
        end
    end

    assign bus.full         = full;
    assign bus.redirect_gnt = redirect;
    assign bus.rand_num     = lfsr[1:0];
    assign bus.ovf_err      = ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr     <= '0;
            ovf    <= 1'b0;
            lfsr   <= 8'hA5;
        end else begin
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            count <= count + (PW + 1)'(push_ok) - (PW + 1)'(pop);
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop && !redirect) begin
                rr <= pick_idx + 2'd1;
            end
            if (bus.push_vld && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.push_flit;
        end
    end
endmodule

// File: doc/side_buf_ctrl.md
SIDE_BUF_CTRL -- requirements
Module: side_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, side-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_TH, default 8, blocked cycles before a forced redirect (1..255).
REQ-003 SHALL run on one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- push_vld  in  1  deflected flit offered to buffer.
- push_flit  in  flit_int_t  flit to store.
- free_vec  in  4  one-hot-or-more mask of empty router input slots this cycle.
- full  out  1  buffer holds DEPTH flits.
- redirect_gnt  out  1  forced redirect this cycle.
- rand_num  out  2  pseudo-random channel select for the eject picker.
- reinj_vld  out  1  head flit re-injected this cycle.
- reinj_chnl  out  4  one-hot target slot of re-injection.
- reinj_flit  out  flit_int_t  head flit (all zero when reinj_vld=0).
- ovf_err  out  1  sticky: push attempted while full.

Function
REQ-005 SHALL store flits in a DEPTH-entry circular FIFO with registered rd/wr pointers and count (0..DEPTH).
REQ-006 SHALL derive full = (count==DEPTH) and empty = (count==0) from registered count only.
REQ-007 SHALL write push_flit at wr_ptr when push_vld=1 and full=0; pointer wraps DEPTH-1 -> 0.
REQ-008 SHALL drop push_vld=1 while full=1, leave state unchanged, and set ovf_err until reset.
REQ-009 SHALL make a pushed flit visible at the head no earlier than the next cycle (no bypass; min latency 1).
REQ-010 SHALL assert reinj_vld when empty=0 and free_vec!=0 (normal re-injection), popping the head that cycle.
REQ-011 SHALL pick reinj_chnl as the first set bit of free_vec searching upward from a 2-bit rr pointer, wrapping 3 -> 0; rr advances to chosen+1 after each normal re-injection.
REQ-012 SHALL keep starve_cnt (8 bit): increment when empty=0 and free_vec==0 and no forced redirect; clear on any pop or when empty.
REQ-013 SHALL assert redirect_gnt combinationally when empty=0, free_vec==0, starve_cnt==STARVE_TH; that cycle reinj_vld=1, reinj_chnl = one-hot(rand_num), head popped, starve_cnt cleared next cycle.
REQ-014 SHALL accept a simultaneous push and pop with count unchanged; push into full with same-cycle pop is still dropped (full is registered).
REQ-015 SHALL drive rand_num = lfsr[1:0] from an 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing every cycle.
REQ-016 SHALL drive reinj_chnl=0 and reinj_flit=0 whenever reinj_vld=0.

Reset
REQ-017 SHALL on reset clear pointers, count, starve_cnt, rr, ovf_err; load lfsr=8'hA5.
REQ-018 SHALL after reset drive full=0, redirect_gnt=0, reinj_vld=0, reinj_chnl=0, reinj_flit=0, ovf_err=0, rand_num=2'b01.
REQ-019 SHALL discard all buffered flits on reset asserted mid-operation; no pop output in the reset cycle.

Configuration
REQ-020 SHALL, with SIDE_BUF_STARVE_EN defined, implement starve_cnt and forced redirect per REQ-012/013.
REQ-021 SHALL, without SIDE_BUF_STARVE_EN, omit starve_cnt, tie redirect_gnt=0, and re-inject only via REQ-010.

Verification
REQ-022 Reset, then 4 pushes flits A..D, free_vec=0 -> full=1 cycle after 4th push; 5th push sets ovf_err=1, count stays 4.
REQ-023 Buffer holds A, free_vec=4'b1010, rr=0 -> reinj_vld=1, reinj_chnl=4'b0010, reinj_flit=A, rr=2 next cycle.
REQ-024 (EN) Buffer holds A, free_vec=0 for STARVE_TH=8 cycles -> 9th cycle redirect_gnt=1, reinj_chnl=one-hot(rand_num), A popped, starve_cnt=0.
REQ-025 count=2, push_vld=1, free_vec=4'b0001 same cycle -> count stays 2, FIFO order preserved on drain.
REQ-026 Push into empty buffer with free_vec=4'b1111 -> reinj_vld=0 that cycle, =1 next cycle.
REQ-027 Reset asserted with count=3 -> count=0, full=0, reinj_vld=0 immediately; rand_num=2'b01.
